ee357_muldiv: RTL and testbench

Sequential multiply/divide unit for the multicycle CPU, sitting beside ee357_alu. It executes the MIPS MULT/MULTU/DIV/DIVU functs with a start/busy/done handshake and holds the HI/LO registers. Iterative shift-add multiply and restoring divide run on magnitudes; a final fix-up cycle applies the sign. The control FSM is the requester and this block is the responder.

---
 rtl/ee357_defs.sv | 29 ++
 rtl/ee357_muldiv_step.sv | 30 +++
 rtl/ee357_muldiv.sv | 143 ++++++++++++++
 tb/tb_ee357_muldiv.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/ee357_defs.sv
// rtl/ee357_defs.sv - shared functs and FSM state encoding for the ALU and the mul/div unit
package ee357_defs;

  localparam logic [5:0] FUNC_ADD   = 6'b100000;
  localparam logic [5:0] FUNC_ADDU  = 6'b100001;
  localparam logic [5:0] FUNC_SUB   = 6'b100010;
  localparam logic [5:0] FUNC_SUBU  = 6'b100011;
  localparam logic [5:0] FUNC_AND   = 6'b100100;
  localparam logic [5:0] FUNC_OR    = 6'b100101;
  localparam logic [5:0] FUNC_XOR   = 6'b100110;
  localparam logic [5:0] FUNC_NOR   = 6'b100111;
  localparam logic [5:0] FUNC_SLT   = 6'b101010;
  localparam logic [5:0] FUNC_SLTU  = 6'b101011;
  localparam logic [5:0] FUNC_MULT  = 6'b011000;
  localparam logic [5:0] FUNC_MULTU = 6'b011001;
  localparam logic [5:0] FUNC_DIV   = 6'b011010;
  localparam logic [5:0] FUNC_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  function automatic logic is_muldiv(input logic [5:0] f);
    return (f == FUNC_MULT) || (f == FUNC_MULTU) || (f == FUNC_DIV) || (f == FUNC_DIVU);
  endfunction

endpackage

// File: rtl/ee357_muldiv_step.sv
// rtl/ee357_muldiv_step.sv - one shift-add multiply or restoring-divide iteration
module ee357_muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic               i_div,
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_opnd,
  output logic [2*WIDTH-1:0] o_acc,
  output logic               o_qbit
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_rem_sh;
  logic [WIDTH:0] w_diff;

  // Multiply: {partial product, multiplier}. Divide: {remainder, dividend shifting into quotient}.
  always_comb begin
    w_sum    = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_opnd} : '0);
    w_rem_sh = {i_acc[2*WIDTH-1:WIDTH], i_acc[WIDTH-1]};
    w_diff   = w_rem_sh - {1'b0, i_opnd};
    if (i_div) begin
      o_qbit = ~w_diff[WIDTH];
      o_acc  = {(o_qbit ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0]), i_acc[WIDTH-2:0], 1'b0};
    end else begin
      o_qbit = 1'b0;
      o_acc  = {w_sum, i_acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/ee357_muldiv.sv
// rtl/ee357_muldiv.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers
// Optional EE357_MULDIV_EARLY_OUT_EN: a zero operand skips RUN and goes straight to FIX.
module ee357_muldiv
  import ee357_defs::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       func,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_opnd;
  logic [WIDTH-1:0]     r_opa_orig;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic                 r_is_div;
  logic                 r_neg_q;
  logic                 r_neg_r;
  logic                 r_dbz;
  logic                 r_dbz_flag;
  logic                 r_busy;
  logic                 r_done;

  logic                 w_signed;
  logic                 w_is_div;
  logic                 w_a_neg;
  logic                 w_b_neg;
  logic                 w_skip;
  logic [WIDTH-1:0]     w_abs_a;
  logic [WIDTH-1:0]     w_abs_b;
  logic [2*WIDTH-1:0]   w_next_acc;
  logic                 w_qbit;
  logic [2*WIDTH-1:0]   w_prod;
  logic [WIDTH-1:0]     w_quot;
  logic [WIDTH-1:0]     w_rem;

  assign w_signed = (func == FUNC_MULT) || (func == FUNC_DIV);
  assign w_is_div = func[1];
  assign w_a_neg  = w_signed & opa[WIDTH-1];
  assign w_b_neg  = w_signed & opb[WIDTH-1];
  assign w_abs_a  = w_a_neg ? -opa : opa;
  assign w_abs_b  = w_b_neg ? -opb : opb;

`ifdef EE357_MULDIV_EARLY_OUT_EN
  assign w_skip = (opa == '0) || (opb == '0);
`else
  assign w_skip = 1'b0;
`endif

  ee357_muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_div  (r_is_div),
    .i_acc  (r_acc),
    .i_opnd (r_opnd),
    .o_acc  (w_next_acc),
    .o_qbit (w_qbit)
  );

  // Remainder follows the dividend sign, so division truncates toward zero.
  assign w_prod = r_neg_q ? -r_acc : r_acc;
  assign w_quot = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_opnd     <= '0;
      r_opa_orig <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_is_div   <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_dbz      <= 1'b0;
      r_dbz_flag <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start && is_muldiv(func)) begin
            r_is_div   <= w_is_div;
            r_opa_orig <= opa;
            r_dbz      <= w_is_div && (opb == '0);
            r_neg_q    <= w_a_neg ^ w_b_neg;
            r_neg_r    <= w_a_neg;
            r_opnd     <= w_is_div ? w_abs_b : w_abs_a;
            r_acc      <= {{WIDTH{1'b0}}, (w_is_div ? w_abs_a : w_abs_b)};
            r_cnt      <= '0;
            r_dbz_flag <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= w_skip ? FIX : RUN;
          end
        end
        RUN: begin
          r_acc <= w_next_acc | {{(2*WIDTH-1){1'b0}}, w_qbit};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(WIDTH-1)) r_state <= FIX;
        end
        FIX: begin
          if (r_dbz) begin
            r_lo       <= '1;
            r_hi       <= r_opa_orig;
            r_dbz_flag <= 1'b1;
          end else if (r_is_div) begin
            r_lo <= w_quot;
            r_hi <= w_rem;
          end else begin
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign hi          = r_hi;
  assign lo          = r_lo;
  assign div_by_zero = r_dbz_flag;

endmodule

// File: tb/tb_ee357_muldiv.sv
// tb/tb_ee357_muldiv.sv - self-checking bench for ee357_muldiv
module tb_ee357_muldiv;
  import ee357_defs::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [5:0]   func = 6'd0;
  logic [W-1:0] opa = '0;
  logic [W-1:0] opb = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         div_by_zero;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } exp_t;

  typedef struct {
    logic [5:0]   func;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[14];

  ee357_muldiv #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .func        (func),
    .opa         (opa),
    .opb         (opb),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", nm, act, exp);
    end
  endtask

  task automatic run_op(input string nm, input logic [5:0] f, input logic [W-1:0] a,
                        input logic [W-1:0] b, input exp_t e, input int glitch);
    int   n;
    int   exp_lat;
    logic busy_ok;
    exp_t got;
    @(negedge clk);
    start = 1'b1; func = f; opa = a; opb = b;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0; func = FUNC_MULTU; opa = $urandom; opb = $urandom;
    chk({nm, "_dbz_clear"}, W'(div_by_zero), '0);
    exp_lat = W + 1;
`ifdef EE357_MULDIV_EARLY_OUT_EN
    if (a == '0 || b == '0) exp_lat = 1;
`endif
    n = 0;
    busy_ok = 1'b1;
    while (!done && n < 200) begin
      if (!busy) busy_ok = 1'b0;
      if (glitch != 0 && n == glitch) begin
        start = 1'b1; func = FUNC_MULTU; opa = 32'd3; opb = 32'd5;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk({nm, "_busy_run"}, W'(busy_ok), W'(1));
    chk({nm, "_latency"}, W'(n), W'(exp_lat));
    chk({nm, "_busy_done"}, W'(busy), '0);
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s_scoreboard: got empty queue expected one entry", nm);
    end else begin
      got = sb.pop_front();
      chk({nm, "_hi"}, hi, got.hi);
      chk({nm, "_lo"}, lo, got.lo);
      chk({nm, "_dbz"}, W'(div_by_zero), W'(got.dbz));
    end
    @(negedge clk);
    chk({nm, "_done_pulse"}, W'(done), '0);
    chk({nm, "_hold_lo"}, lo, e.lo);
  endtask

  initial begin
    int   ndone;
    exp_t e;
    vecs[0]  = '{FUNC_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[1]  = '{FUNC_MULT,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0};
    vecs[2]  = '{FUNC_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0};
    vecs[3]  = '{FUNC_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[4]  = '{FUNC_DIVU,  32'hFFFFFFF9, 32'h00000002, 32'h00000001, 32'h7FFFFFFC, 1'b0};
    vecs[5]  = '{FUNC_DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, 1'b1};
    vecs[6]  = '{FUNC_MULTU, 32'h00000003, 32'h00000005, 32'h00000000, 32'h0000000F, 1'b0};
    vecs[7]  = '{FUNC_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[8]  = '{FUNC_MULT,  32'hFFFFFFFD, 32'hFFFFFFFB, 32'h00000000, 32'h0000000F, 1'b0};
    vecs[9]  = '{FUNC_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
    vecs[10] = '{FUNC_MULTU, 32'h00000000, 32'h12345678, 32'h00000000, 32'h00000000, 1'b0};
    vecs[11] = '{FUNC_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0};
    vecs[12] = '{FUNC_DIV,   32'h00000000, 32'h00000005, 32'h00000000, 32'h00000000, 1'b0};
    vecs[13] = '{FUNC_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_busy", W'(busy), '0);
    chk("rst_done", W'(done), '0);
    chk("rst_hi", hi, '0);
    chk("rst_lo", lo, '0);
    chk("rst_dbz", W'(div_by_zero), '0);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      e = '{vecs[i].hi, vecs[i].lo, vecs[i].dbz};
      run_op($sformatf("v%0d", i), vecs[i].func, vecs[i].a, vecs[i].b, e, 0);
    end

    // Illegal funct must leave the unit idle and HI/LO untouched.
    @(negedge clk);
    start = 1'b1; func = FUNC_ADD; opa = 32'd1; opb = 32'd1;
    @(negedge clk);
    start = 1'b0;
    chk("illegal_busy", W'(busy), '0);
    @(negedge clk);
    chk("illegal_done", W'(done), '0);
    chk("illegal_hi", hi, 32'h40000000);

    e = '{32'h00000000, 32'h80000000, 1'b0};
    run_op("div_min_glitch", FUNC_DIV, 32'h80000000, 32'hFFFFFFFF, e, 10);
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("glitch_extra_done", W'(ndone), '0);
    chk("glitch_lo_hold", lo, 32'h80000000);

    @(negedge clk);
    start = 1'b1; func = FUNC_MULTU; opa = 32'd3; opb = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", W'(busy), '0);
    chk("midrst_done", W'(done), '0);
    chk("midrst_hi", hi, '0);
    chk("midrst_lo", lo, '0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("midrst_no_done", W'(ndone), '0);
    chk("midrst_lo_after", lo, '0);

    e = '{32'h00000000, 32'h0000000F, 1'b0};
    run_op("post_rst_multu", FUNC_MULTU, 32'd3, 32'd5, e, 0);

    chk("sb_empty", W'(sb.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
